// File: rtl/mdu_issue.sv
// Issue/interlock stage between decode and the multiply/divide unit.
// Tracks HI/LO occupancy, stalls dependent MDU ops and captures GPR-writing MDU results.
module mdu_issue #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned MADD_LAT = 5,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] muu_out,
  input  logic        div_zero,
  output logic [31:0] muu_rs,
  output logic [31:0] muu_rt,
  output logic [3:0]  muu_op,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        exc_div_zero
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_MUL   = 4'b0000;
  localparam logic [OP_W-1:0] OP_MULT  = 4'b0001;
  localparam logic [OP_W-1:0] OP_MADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV   = 4'b0011;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'b0101;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'b0110;
  localparam logic [OP_W-1:0] OP_MULTU = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    HILO_BUSY = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] result_q;
  logic              rvalid_q;
  logic              busy_q;
  logic              exc_q;

  logic [OP_W-1:0]   dec_op;
  logic [CNT_W-1:0]  dec_lat;
  logic              is_mdu;
  logic              is_read;
  logic              op_is_div;

  // Opcode/funct to MDU operation code; anything unrecognised decodes to NOP.
  always_comb begin
    dec_op = OP_NOP;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b011000: dec_op = OP_MULT;
        6'b011001: dec_op = OP_MULTU;
        6'b011010: dec_op = OP_DIV;
        6'b011011: dec_op = OP_DIVU;
        6'b010000: dec_op = OP_MFHI;
        6'b010010: dec_op = OP_MFLO;
        default:   dec_op = OP_NOP;
      endcase
    end else if (opcode == 6'b011100) begin
      case (funct)
        6'b000010: dec_op = OP_MUL;
        6'b000000: dec_op = OP_MADD;
        default:   dec_op = OP_NOP;
      endcase
    end
  end

  // HI/LO occupancy for the decoded operation.
  always_comb begin
    dec_lat = CNT_W'(MULT_LAT);
    case (dec_op)
      OP_MADD:         dec_lat = CNT_W'(MADD_LAT);
      OP_DIV, OP_DIVU: dec_lat = CNT_W'(DIV_LAT);
      default:         dec_lat = CNT_W'(MULT_LAT);
    endcase
  end

  assign is_mdu    = (dec_op != OP_NOP);
  assign is_read   = (dec_op == OP_MUL) || (dec_op == OP_MFHI) || (dec_op == OP_MFLO);
  assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      rs_q     <= '0;
      rt_q     <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      exc_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in && is_mdu) begin
            rs_q <= rs_val;
            rt_q <= rt_val;
            op_q <= dec_op;
            if (is_read) begin
              state_q <= READ;
            end else begin
              state_q <= HILO_BUSY;
              cnt_q   <= dec_lat;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          result_q <= muu_out;
          rvalid_q <= 1'b1;
          op_q     <= OP_NOP;
          rs_q     <= '0;
          rt_q     <= '0;
          state_q  <= IDLE;
        end
        HILO_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Final busy cycle: release HI/LO and report a divide by zero.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            rs_q    <= '0;
            rt_q    <= '0;
            busy_q  <= 1'b0;
            exc_q   <= op_is_div & div_zero;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall        = valid_in & is_mdu & (state_q != IDLE);
  assign muu_rs       = rs_q;
  assign muu_rt       = rt_q;
  assign muu_op       = op_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign busy         = busy_q;
  assign exc_div_zero = exc_q;

endmodule
